// File: rtl/sqrt_pkg.sv
// Shared types and width rules for the iterative square-root unit.
package sqrt_pkg;

  typedef enum logic [1:0] {IDLE, SEED, ITER, DONE} state_e;

  function automatic int pairs(input int width);
    return (width + 1) / 2;
  endfunction

  // Two guard bits above the root width keep r' = 4r + pair from overflowing.
  function automatic int rem_width(input int p);
    return p + 2;
  endfunction

  function automatic int k_width(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/sqrt_iter_unit_if.sv
// Four-phase req/fin request bus between a requester and the square-root unit.
interface sqrt_iter_unit_if #(
  parameter int Width = 32
);
  localparam int P = sqrt_pkg::pairs(Width);

  logic             req;
  logic [Width-1:0] x;
  logic             fin;
  logic [P-1:0]     yo;
  logic [P:0]       rem;
  logic             busy;

  modport master (output req, x, input fin, yo, rem, busy);
  modport slave  (input req, x, output fin, yo, rem, busy);
endinterface

// File: rtl/sqrt_pair_lzd.sv
// Priority encoder: index of the highest non-zero bit pair of the radicand.
module sqrt_pair_lzd
  import sqrt_pkg::*;
#(
  parameter int P  = 16,
  parameter int KW = k_width(P)
) (
  input  logic [2*P-1:0] xr,
  output logic [KW-1:0]  k0,
  output logic           zero
);

  always_comb begin
    k0   = '0;
    zero = 1'b1;
    for (int j = 0; j < P; j++) begin
      if (xr[2*j +: 2] != 2'b00) begin
        k0   = KW'(j);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sqrt_iter_unit.sv
// Restoring digit-by-digit integer square root, one root bit per clock,
// starting at the highest non-zero bit pair of the radicand.
module sqrt_iter_unit
  import sqrt_pkg::*;
#(
  parameter int Width   = 32,
  parameter bit SyncReq = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  sqrt_iter_unit_if.slave bus
);

  localparam int P  = pairs(Width);
  localparam int RW = rem_width(P);
  localparam int KW = k_width(P);

  logic rq;

  generate
    if (SyncReq) begin : g_sync
      logic [1:0] sync_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], bus.req};
      end
      assign rq = sync_q[1];
    end else begin : g_nosync
      assign rq = bus.req;
    end
  endgenerate

  state_e          state_q, state_d;
  logic [2*P-1:0]  xr_q, xr_d;
  logic [P-1:0]    root_q, root_d;
  logic [RW-1:0]   r_q, r_d;
  logic [KW-1:0]   k_q, k_d;
  logic            fin_q, fin_d;
  logic [P-1:0]    yo_q, yo_d;
  logic [P:0]      rem_q, rem_d;

  logic [KW-1:0]   k0;
  logic            xr_zero;

  sqrt_pair_lzd #(.P(P), .KW(KW)) u_lzd (
    .xr   (xr_q),
    .k0   (k0),
    .zero (xr_zero)
  );

  // One restoring step: bring down pair k, trial-subtract 4*root+1.
  logic [1:0]    pair_k;
  logic [RW-1:0] r_sh, t_val, r_nx;
  logic          ge;
  logic [P-1:0]  root_nx;

  always_comb begin
    pair_k  = xr_q[{k_q, 1'b0} +: 2];
    r_sh    = (r_q << 2) | RW'(pair_k);
    t_val   = {root_q, 2'b01};
    ge      = (r_sh >= t_val);
    r_nx    = ge ? (r_sh - t_val) : r_sh;
    root_nx = (root_q << 1) | P'(ge);
  end

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    root_d  = root_q;
    r_d     = r_q;
    k_d     = k_q;
    fin_d   = fin_q;
    yo_d    = yo_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (rq) begin
          xr_d    = (2*P)'(bus.x);
          root_d  = '0;
          r_d     = '0;
          state_d = SEED;
        end
      end
      SEED: begin
        if (xr_zero) begin
          yo_d    = '0;
          rem_d   = '0;
          fin_d   = 1'b1;
          state_d = DONE;
        end else begin
          k_d     = k0;
          state_d = ITER;
        end
      end
      ITER: begin
        root_d = root_nx;
        r_d    = r_nx;
        if (k_q == '0) begin
          yo_d    = root_nx;
          rem_d   = (P+1)'(r_nx);
          fin_d   = 1'b1;
          state_d = DONE;
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      DONE: begin
        if (!rq) begin
          fin_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xr_q    <= '0;
      root_q  <= '0;
      r_q     <= '0;
      k_q     <= '0;
      fin_q   <= 1'b0;
      yo_q    <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      root_q  <= root_d;
      r_q     <= r_d;
      k_q     <= k_d;
      fin_q   <= fin_d;
      yo_q    <= yo_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.fin  = fin_q;
  assign bus.yo   = yo_q;
  assign bus.rem  = rem_q;
  assign bus.busy = (state_q == SEED) || (state_q == ITER);

endmodule
